// File: rtl/warp_issue_ctrl.sv
// Issue controller between the warp table FIFO and instruction fetch: pops a warp,
// issues it over valid/ready, requeues it with PC advanced, and merges redirects.
module warp_issue_ctrl #(
  parameter int unsigned LOG2_NUM_WARPS       = 3,
  parameter int unsigned MACHINE_WIDTH        = 64,
  parameter int unsigned NUM_THREADS_PER_WARP = 8,
  parameter int unsigned INSTR_BYTES          = 4,
  parameter int unsigned LINE_WIDTH           = LOG2_NUM_WARPS + MACHINE_WIDTH + NUM_THREADS_PER_WARP
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            fifo_is_empty,
  input  logic                            fifo_is_full,
  output logic                            fifo_read_en,
  input  logic [LINE_WIDTH-1:0]           fifo_read_data,
  output logic                            fifo_write_en,
  output logic [LINE_WIDTH-1:0]           fifo_write_data,
  output logic                            fetch_valid,
  input  logic                            fetch_ready,
  output logic [LOG2_NUM_WARPS-1:0]       fetch_warp_id,
  output logic [MACHINE_WIDTH-1:0]        fetch_pc,
  output logic [NUM_THREADS_PER_WARP-1:0] fetch_mask,
  input  logic                            redirect_valid,
  output logic                            redirect_ready,
  input  logic [LINE_WIDTH-1:0]           redirect_data,
  input  logic                            halt_valid,
  input  logic [LOG2_NUM_WARPS-1:0]       halt_warp_id
);

  localparam int unsigned NUM_WARPS = 1 << LOG2_NUM_WARPS;

  typedef enum logic [1:0] {S_POP, S_CAPTURE, S_ISSUE, S_REQUEUE} state_e;

  state_e                            state_q, state_d;
  logic [LOG2_NUM_WARPS-1:0]         id_q, id_d;
  logic [MACHINE_WIDTH-1:0]          pc_q, pc_d;
  logic [NUM_THREADS_PER_WARP-1:0]   mask_q, mask_d;
  logic [NUM_WARPS-1:0]              halted_q, halted_d;
  logic                              rbuf_valid_q, rbuf_valid_d;
  logic [LINE_WIDTH-1:0]             rbuf_q, rbuf_d;

  logic [LOG2_NUM_WARPS-1:0]         cap_id;
  logic [MACHINE_WIDTH-1:0]          cap_pc;
  logic [NUM_THREADS_PER_WARP-1:0]   cap_mask;
  logic [LOG2_NUM_WARPS-1:0]         redirect_id;
  logic [MACHINE_WIDTH-1:0]          next_pc;
  logic                              warp_halted;
  logic                              requeue_wr;
  logic                              drain_wr;
  logic                              redirect_fire;

  assign cap_id      = fifo_read_data[LINE_WIDTH-1 -: LOG2_NUM_WARPS];
  assign cap_pc      = fifo_read_data[NUM_THREADS_PER_WARP +: MACHINE_WIDTH];
  assign cap_mask    = fifo_read_data[NUM_THREADS_PER_WARP-1:0];
  assign redirect_id = redirect_data[LINE_WIDTH-1 -: LOG2_NUM_WARPS];
  assign next_pc     = pc_q + MACHINE_WIDTH'(INSTR_BYTES);

  // A halt arriving in the requeue cycle itself must still suppress the write.
  assign warp_halted   = halted_q[id_q] | (halt_valid && (halt_warp_id == id_q));
  assign requeue_wr    = (state_q == S_REQUEUE) && !warp_halted && !fifo_is_full;
  assign drain_wr      = rbuf_valid_q && !fifo_is_full && !requeue_wr;
  assign redirect_fire = redirect_valid && !rbuf_valid_q;

  assign fifo_read_en   = (state_q == S_POP) && !fifo_is_empty;
  assign fifo_write_en  = requeue_wr | drain_wr;
  assign fetch_valid    = (state_q == S_ISSUE);
  assign fetch_warp_id  = id_q;
  assign fetch_pc       = pc_q;
  assign fetch_mask     = mask_q;
  assign redirect_ready = !rbuf_valid_q;

  always_comb begin
    fifo_write_data = '0;
    if (requeue_wr) begin
      fifo_write_data = {id_q, next_pc, mask_q};
    end else if (drain_wr) begin
      fifo_write_data = rbuf_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    id_d         = id_q;
    pc_d         = pc_q;
    mask_d       = mask_q;
    halted_d     = halted_q;
    rbuf_valid_d = rbuf_valid_q;
    rbuf_d       = rbuf_q;

    unique case (state_q)
      S_POP: begin
        if (!fifo_is_empty) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        id_d    = cap_id;
        pc_d    = cap_pc;
        mask_d  = cap_mask;
        state_d = (cap_mask == '0) ? S_POP : S_ISSUE;
      end
      S_ISSUE: begin
        if (fetch_ready) state_d = S_REQUEUE;
      end
      S_REQUEUE: begin
        if (warp_halted || !fifo_is_full) state_d = S_POP;
      end
      default: state_d = S_POP;
    endcase

    // Redirect clear is applied after the halt set so it wins on the same ID.
    if (halt_valid) halted_d[halt_warp_id] = 1'b1;
    if (redirect_fire) begin
      halted_d[redirect_id] = 1'b0;
      rbuf_valid_d          = 1'b1;
      rbuf_d                = redirect_data;
    end else if (drain_wr) begin
      rbuf_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_POP;
      id_q         <= '0;
      pc_q         <= '0;
      mask_q       <= '0;
      halted_q     <= '0;
      rbuf_valid_q <= 1'b0;
      rbuf_q       <= '0;
    end else begin
      state_q      <= state_d;
      id_q         <= id_d;
      pc_q         <= pc_d;
      mask_q       <= mask_d;
      halted_q     <= halted_d;
      rbuf_valid_q <= rbuf_valid_d;
      rbuf_q       <= rbuf_d;
    end
  end

endmodule

// File: tb/tb_warp_issue_ctrl.sv
// Scoreboard bench for warp_issue_ctrl: a small warp-table model feeds pops,
// expected fetch issues and table writes are queued and checked by a monitor.
module tb_warp_issue_ctrl;

  localparam int unsigned LW = 3;
  localparam int unsigned MW = 64;
  localparam int unsigned NT = 8;
  localparam int unsigned LINE = LW + MW + NT;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            fifo_is_empty = 1'b1;
  logic            fifo_is_full = 1'b0;
  logic            fifo_read_en;
  logic [LINE-1:0] fifo_read_data = '0;
  logic            fifo_write_en;
  logic [LINE-1:0] fifo_write_data;
  logic            fetch_valid;
  logic            fetch_ready = 1'b1;
  logic [LW-1:0]   fetch_warp_id;
  logic [MW-1:0]   fetch_pc;
  logic [NT-1:0]   fetch_mask;
  logic            redirect_valid = 1'b0;
  logic            redirect_ready;
  logic [LINE-1:0] redirect_data = '0;
  logic            halt_valid = 1'b0;
  logic [LW-1:0]   halt_warp_id = '0;

  int n_checks = 0;
  int n_fail = 0;

  logic [LINE-1:0] table_q[$];
  logic [LINE-1:0] exp_fetch[$];
  logic [LINE-1:0] exp_write[$];
  logic            pop_pending = 1'b0;

  warp_issue_ctrl #(
    .LOG2_NUM_WARPS(LW),
    .MACHINE_WIDTH(MW),
    .NUM_THREADS_PER_WARP(NT),
    .INSTR_BYTES(4)
  ) dut (
    .clk(clk), .reset(reset),
    .fifo_is_empty(fifo_is_empty), .fifo_is_full(fifo_is_full),
    .fifo_read_en(fifo_read_en), .fifo_read_data(fifo_read_data),
    .fifo_write_en(fifo_write_en), .fifo_write_data(fifo_write_data),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_warp_id(fetch_warp_id), .fetch_pc(fetch_pc), .fetch_mask(fetch_mask),
    .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
    .redirect_data(redirect_data),
    .halt_valid(halt_valid), .halt_warp_id(halt_warp_id)
  );

  always #5 clk = ~clk;

  function automatic logic [LINE-1:0] mk(input logic [LW-1:0] id, input logic [MW-1:0] pc,
                                         input logic [NT-1:0] mask);
    return {id, pc, mask};
  endfunction

  task automatic check(input string nm, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // which: 0 = fifo_read_en, 1 = fetch_valid, 2 = fifo_write_en
  task automatic wait_for(input string nm, input int which);
    bit seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      case (which)
        0: seen = fifo_read_en;
        1: seen = fetch_valid;
        default: seen = fifo_write_en;
      endcase
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s: got timeout expected event within 50 cycles", nm);
    end
  endtask

  // Warp table model: a pop request seen in a cycle is served on the next edge.
  always @(negedge clk) pop_pending = reset && fifo_read_en;
  always @(posedge clk) begin
    #1;
    if (pop_pending && table_q.size() > 0) fifo_read_data = table_q.pop_front();
    pop_pending = 1'b0;
    fifo_is_empty = (table_q.size() == 0);
  end

  // Monitor: compares every fetch handshake and every table write to the scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      if (fetch_valid && fetch_ready) begin
        if (exp_fetch.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL fetch_unexpected: got %h expected none",
                   {fetch_warp_id, fetch_pc, fetch_mask});
        end else begin
          check("fetch_issue", {5'd0, fetch_warp_id, fetch_pc, fetch_mask},
                {5'd0, exp_fetch.pop_front()});
        end
      end
      if (fifo_write_en) begin
        check("write_while_full", {79'd0, fifo_is_full}, 80'd0);
        if (exp_write.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL write_unexpected: got %h expected none", fifo_write_data);
        end else begin
          check("write_data", {5'd0, fifo_write_data}, {5'd0, exp_write.pop_front()});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "watchdog");
  end

  task automatic check_reset_values(input string nm);
    check({nm, "_read_en"}, {79'd0, fifo_read_en}, 80'd0);
    check({nm, "_write_en"}, {79'd0, fifo_write_en}, 80'd0);
    check({nm, "_write_data"}, {5'd0, fifo_write_data}, 80'd0);
    check({nm, "_fetch_valid"}, {79'd0, fetch_valid}, 80'd0);
    check({nm, "_fetch_out"}, {5'd0, fetch_warp_id, fetch_pc, fetch_mask}, 80'd0);
    check({nm, "_redirect_ready"}, {79'd0, redirect_ready}, 80'd1);
  endtask

  initial begin
    // Reset values
    #12;
    check_reset_values("rst");
    tick();
    reset = 1'b1;
    tick();

    // Basic issue and latency
    fetch_ready = 1'b1;
    table_q.push_back(mk(3'd2, 64'h100, 8'hFF));
    exp_fetch.push_back(mk(3'd2, 64'h100, 8'hFF));
    exp_write.push_back(mk(3'd2, 64'h104, 8'hFF));
    wait_for("basic_pop", 0);
    @(negedge clk); check("basic_capture_no_valid", {79'd0, fetch_valid}, 80'd0);
    @(negedge clk); check("basic_valid_t2", {79'd0, fetch_valid}, 80'd1);
    @(negedge clk); check("basic_write_t3", {79'd0, fifo_write_en}, 80'd1);
    @(negedge clk); check("basic_idle_after", {79'd0, fifo_write_en}, 80'd0);

    // Fetch backpressure
    tick();
    fetch_ready = 1'b0;
    table_q.push_back(mk(3'd5, 64'h2000, 8'h0F));
    exp_fetch.push_back(mk(3'd5, 64'h2000, 8'h0F));
    exp_write.push_back(mk(3'd5, 64'h2004, 8'h0F));
    wait_for("bp_valid", 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_out", {5'd0, fetch_warp_id, fetch_pc, fetch_mask},
            {5'd0, mk(3'd5, 64'h2000, 8'h0F)});
      check("bp_no_write_pop", {78'd0, fifo_write_en, fifo_read_en}, 80'd0);
    end
    tick();
    fetch_ready = 1'b1;
    @(negedge clk); check("bp_handshake_no_write", {79'd0, fifo_write_en}, 80'd0);
    @(negedge clk); check("bp_requeue_next", {79'd0, fifo_write_en}, 80'd1);

    // Halt during ISSUE suppresses requeue; redirect clears and is written verbatim
    tick();
    fetch_ready = 1'b0;
    table_q.push_back(mk(3'd3, 64'h300, 8'h01));
    exp_fetch.push_back(mk(3'd3, 64'h300, 8'h01));
    wait_for("halt_valid_issue", 1);
    tick();
    halt_valid = 1'b1; halt_warp_id = 3'd3; fetch_ready = 1'b1;
    tick();
    halt_valid = 1'b0;
    @(negedge clk); check("halt_no_requeue", {79'd0, fifo_write_en}, 80'd0);
    tick();
    redirect_valid = 1'b1;
    redirect_data = mk(3'd3, 64'h40, 8'h0F);
    exp_write.push_back(mk(3'd3, 64'h40, 8'h0F));
    @(negedge clk);
    check("redir_ready_empty", {79'd0, redirect_ready}, 80'd1);
    check("redir_not_same_cycle", {79'd0, fifo_write_en}, 80'd0);
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("redir_drain", {79'd0, fifo_write_en}, 80'd1);
    check("redir_busy", {79'd0, redirect_ready}, 80'd0);
    tick();
    table_q.push_back(mk(3'd3, 64'h500, 8'h03));
    exp_fetch.push_back(mk(3'd3, 64'h500, 8'h03));
    exp_write.push_back(mk(3'd3, 64'h504, 8'h03));
    wait_for("unhalted_requeue", 2);

    // Redirect colliding with a requeue write
    tick();
    table_q.push_back(mk(3'd1, 64'h1000, 8'hAA));
    exp_fetch.push_back(mk(3'd1, 64'h1000, 8'hAA));
    exp_write.push_back(mk(3'd1, 64'h1004, 8'hAA));
    exp_write.push_back(mk(3'd6, 64'h7000, 8'h33));
    wait_for("coll_pop", 0);
    tick(); tick(); tick();
    redirect_valid = 1'b1;
    redirect_data = mk(3'd6, 64'h7000, 8'h33);
    @(negedge clk);
    check("coll_requeue_write", {79'd0, fifo_write_en}, 80'd1);
    check("coll_accept", {79'd0, redirect_ready}, 80'd1);
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("coll_buffer_busy", {79'd0, redirect_ready}, 80'd0);
    check("coll_drain_write", {79'd0, fifo_write_en}, 80'd1);
    @(negedge clk);
    check("coll_buffer_free", {79'd0, redirect_ready}, 80'd1);

    // Full FIFO stalls the requeue
    tick();
    table_q.push_back(mk(3'd4, 64'h400, 8'h0F));
    exp_fetch.push_back(mk(3'd4, 64'h400, 8'h0F));
    exp_write.push_back(mk(3'd4, 64'h404, 8'h0F));
    wait_for("full_pop", 0);
    tick(); tick();
    fifo_is_full = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); check("full_no_write", {79'd0, fifo_write_en}, 80'd0);
    end
    tick();
    fifo_is_full = 1'b0;
    @(negedge clk); check("full_release_write", {79'd0, fifo_write_en}, 80'd1);
    @(negedge clk); check("full_single_write", {79'd0, fifo_write_en}, 80'd0);

    // PC wrap on requeue
    tick();
    table_q.push_back(mk(3'd7, 64'hFFFF_FFFF_FFFF_FFFC, 8'h80));
    exp_fetch.push_back(mk(3'd7, 64'hFFFF_FFFF_FFFF_FFFC, 8'h80));
    exp_write.push_back(mk(3'd7, 64'h0, 8'h80));
    wait_for("wrap_requeue", 2);

    // Zero-mask entry is dropped
    tick();
    table_q.push_back(mk(3'd0, 64'h900, 8'h00));
    wait_for("zero_pop", 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("zero_no_fetch", {78'd0, fetch_valid, fifo_write_en}, 80'd0);
    end

    // Reset mid-ISSUE, with warp 5 halted just before
    tick();
    fetch_ready = 1'b0;
    table_q.push_back(mk(3'd2, 64'h600, 8'h3C));
    wait_for("rst_issue_valid", 1);
    tick();
    halt_valid = 1'b1; halt_warp_id = 3'd5;
    tick();
    halt_valid = 1'b0;
    #2 reset = 1'b0;
    #1 check_reset_values("midrst");
    tick(); tick();
    reset = 1'b1;
    fetch_ready = 1'b1;
    tick();
    table_q.push_back(mk(3'd5, 64'h800, 8'h01));
    exp_fetch.push_back(mk(3'd5, 64'h800, 8'h01));
    exp_write.push_back(mk(3'd5, 64'h804, 8'h01));
    wait_for("post_reset_requeue", 2);

    repeat (10) @(negedge clk);
    check("fetch_scoreboard_empty", 80'(exp_fetch.size()), 80'd0);
    check("write_scoreboard_empty", 80'(exp_write.size()), 80'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
